rf_vote_agg: RTL and testbench
==============================

// Module: rf_vote_agg
// PURPOSE
//  Downstream aggregator for the random-forest IDS: collects the class_out/done pulses of
//  N_TREES decision-tree engines, accumulates one vote per tree sequentially, resolves the
//  majority class and presents it on a valid/ready interface to the alert/host stage.
//  Trees finish at different times; each tree contributes exactly one vote per round.
// PARAMETERS
//  N_TREES    5  number of tree engines feeding this block (1..15)
//  CLS_W      2  width of one tree class code
//  N_CLASSES  4  number of classes (<= 2**CLS_W)
// PORTS
//  clk         in   1               clock
//  rst         in   1               asynchronous, active-high reset
//  tree_class  in   N_TREES*CLS_W   class of tree i at [i*CLS_W +: CLS_W], valid with tree_done[i]
//  tree_done   in   N_TREES         one-cycle done pulse per tree
//  clear       in   1               synchronous abort: drop round, clear sticky flags
//  pred_class  out  CLS_W           majority class, stable while pred_valid
//  pred_conf   out  CW              vote count of pred_class, CW=$clog2(N_TREES+1)
//  pred_tie    out  1               another class reached the same max count
//  pred_valid  out  1               result available; held until pred_ready
//  pred_ready  in   1               consumer accepts result
//  busy        out  1               state != S_COLLECT
//  overrun     out  1               sticky: a done pulse was dropped
// BEHAVIOUR
//  Reset: state=S_COLLECT, got=0, all counts=0, pred_class=0, pred_conf=0, pred_tie=0,
//   pred_valid=0, overrun=0, busy=0. Reset mid-round discards everything.
//  S_COLLECT: each tree i with tree_done[i]&&!got[i] latches its class, sets got[i]; several
//   trees may finish in the same cycle. tree_done[i]&&got[i] -> overrun<=1, pulse ignored.
//   Edge at which got becomes all ones -> S_COUNT, idx<=0.
//  S_COUNT: one tree per cycle: count[cls[idx]]++, idx++; after idx==N_TREES-1 -> S_RESOLVE.
//   Count width CW; sum of counts == N_TREES, no overflow possible.
//  S_RESOLVE: argmax over counts; tie-break to lowest class index; pred_tie=1 if any other
//   class has equal count; register pred_*, pred_valid<=1 -> S_OUT.
//  S_OUT: outputs frozen; pred_valid&&pred_ready -> pred_valid<=0, got/counts<=0, -> S_COLLECT.
//   ready may be high before valid; no combinational path from ready to valid.
//  Latency: pred_valid rises N_TREES+1 cycles after the edge where the last done is latched
//   (N_TREES count cycles + 1 resolve); one round at minimum every N_TREES+3 cycles.
//  Any tree_done outside S_COLLECT -> overrun<=1, vote dropped (never queued).
//  clear (sync, below rst, above all else): -> S_COLLECT, got/counts/pred_valid/overrun<=0;
//   a tree_done in the same cycle as clear is dropped and does not set overrun.
//  Classes >= N_CLASSES counted in no bucket (still consume a vote slot).
// STRUCTURE
//  rf_pkg: vote_state_t {S_COLLECT,S_COUNT,S_RESOLVE,S_OUT}, CLS_W, N_CLASSES, count type.
//  Sub-module rf_argmax: combinational; counts vector in -> max index, max value, tie flag.
//  Top: FSM, got mask, class latches, idx counter, count registers, output regs.
// TESTING
//  Defaults; trees 0..4 done in one cycle with classes 1,1,2,1,3 -> pred_class=1, conf=3,
//   tie=0, valid exactly 6 cycles after the latching edge.
//  Staggered done pulses (trees 4,0,2,1,3 on separate cycles), classes 2,2,0,0,1 -> class 0,
//   conf=2, tie=1 (lowest-index tie-break).
//  Tree 2 pulses twice in one round -> overrun=1, second class ignored; result unchanged.
//  Hold pred_ready=0 for 10 cycles then pulse -> pred_* stable, tree_done during wait sets
//   overrun; new round starts next cycle after handshake.
//  Assert clear mid S_COUNT, and rst mid S_COLLECT -> all outputs to reset values, next round
//   counts only post-clear/post-reset votes.
//  All trees vote class 3 -> pred_class=3, conf=5, tie=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and defaults for the random-forest vote aggregator.
package rf_pkg;

  // Round sequencing: gather votes, tally them one per cycle, pick the winner, present it.
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_COUNT   = 2'd1,
    S_RESOLVE = 2'd2,
    S_OUT     = 2'd3
  } vote_state_t;

  localparam int CLS_W        = 2;
  localparam int N_CLASSES    = 4;
  localparam int N_TREES_DFLT = 5;

  // A bucket must hold every tree voting for the same class.
  localparam int CNT_W = $clog2(N_TREES_DFLT + 1);
  typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/rf_argmax.sv
// Combinational argmax over the per-class vote buckets.
// The lowest class index wins a tie; tie flags any other class sharing the maximum.
module rf_argmax #(
  parameter int N_CLASSES = 4,
  parameter int CW        = 3,
  parameter int CLS_W     = 2
) (
  input  logic [N_CLASSES*CW-1:0] counts,
  output logic [CLS_W-1:0]        max_idx,
  output logic [CW-1:0]           max_val,
  output logic                    tie
);
  import rf_pkg::*;

  // Strict greater-than keeps the first (lowest) index holding the maximum.
  always_comb begin
    max_idx = '0;
    max_val = counts[CW-1:0];
    tie     = 1'b0;
    for (int k = 1; k < N_CLASSES; k++) begin
      if (counts[k*CW +: CW] > max_val) begin
        max_val = counts[k*CW +: CW];
        max_idx = CLS_W'(k);
      end
    end
    for (int k = 0; k < N_CLASSES; k++) begin
      if ((CLS_W'(k) != max_idx) && (counts[k*CW +: CW] == max_val)) begin
        tie = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_vote_agg.sv
// Majority-vote aggregator: one vote per tree per round, sequential tally,
// argmax resolve, result held on a valid/ready output.
//
// Output handshake: pred_valid rises only from registered state and stays high,
// with pred_class/pred_conf/pred_tie frozen, until a cycle in which pred_ready is
// also high; that edge retires the result. pred_ready may be high early and never
// feeds back combinationally into pred_valid.
module rf_vote_agg #(
  parameter int N_TREES   = rf_pkg::N_TREES_DFLT,
  parameter int CLS_W     = rf_pkg::CLS_W,
  parameter int N_CLASSES = rf_pkg::N_CLASSES,
  localparam int CW       = $clog2(N_TREES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_TREES*CLS_W-1:0] tree_class,
  input  logic [N_TREES-1:0]       tree_done,
  input  logic                     clear,
  output logic [CLS_W-1:0]         pred_class,
  output logic [CW-1:0]            pred_conf,
  output logic                     pred_tie,
  output logic                     pred_valid,
  input  logic                     pred_ready,
  output logic                     busy,
  output logic                     overrun
);
  import rf_pkg::*;

  localparam int IW = (N_TREES > 1) ? $clog2(N_TREES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_TREES - 1);

  vote_state_t             state_q, state_d;
  logic [N_TREES-1:0]      got_q;
  logic [CLS_W-1:0]        cls_q [N_TREES];
  logic [IW-1:0]           idx_q;
  logic [N_CLASSES*CW-1:0] cnt_q;
  logic [CLS_W-1:0]        am_idx;
  logic [CW-1:0]           am_val;
  logic                    am_tie;
  logic                    all_got;

  // Round is complete on the edge where the last outstanding tree reports.
  assign all_got = &(got_q | tree_done);
  assign busy    = (state_q != S_COLLECT);

  rf_argmax #(
    .N_CLASSES (N_CLASSES),
    .CW        (CW),
    .CLS_W     (CLS_W)
  ) u_argmax (
    .counts  (cnt_q),
    .max_idx (am_idx),
    .max_val (am_val),
    .tie     (am_tie)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_COLLECT;
    else     state_q <= state_d;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: if (all_got) state_d = S_COUNT;
        S_COUNT:   if (idx_q == IDX_LAST) state_d = S_RESOLVE;
        S_RESOLVE: state_d = S_OUT;
        S_OUT:     if (pred_valid && pred_ready) state_d = S_COLLECT;
        default:   state_d = S_COLLECT;
      endcase
    end
  end

  // Datapath: vote latches, tally buckets, result registers and the sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      pred_class <= '0;
      pred_conf  <= '0;
      pred_tie   <= 1'b0;
      pred_valid <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_TREES; i++) cls_q[i] <= '0;
    end else if (clear) begin
      // Abort: votes arriving alongside clear are discarded without flagging overrun.
      got_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      pred_class <= '0;
      pred_conf  <= '0;
      pred_tie   <= 1'b0;
      pred_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          idx_q <= '0;
          for (int i = 0; i < N_TREES; i++) begin
            if (tree_done[i]) begin
              if (got_q[i]) begin
                overrun <= 1'b1;
              end else begin
                got_q[i] <= 1'b1;
                cls_q[i] <= tree_class[i*CLS_W +: CLS_W];
              end
            end
          end
        end
        S_COUNT: begin
          if (|tree_done) overrun <= 1'b1;
          // Out-of-range classes match no bucket but still use their slot.
          for (int k = 0; k < N_CLASSES; k++) begin
            if (cls_q[idx_q] == CLS_W'(k)) begin
              cnt_q[k*CW +: CW] <= cnt_q[k*CW +: CW] + CW'(1);
            end
          end
          idx_q <= idx_q + IW'(1);
        end
        S_RESOLVE: begin
          if (|tree_done) overrun <= 1'b1;
          pred_class <= am_idx;
          pred_conf  <= am_val;
          pred_tie   <= am_tie;
          pred_valid <= 1'b1;
        end
        S_OUT: begin
          if (|tree_done) overrun <= 1'b1;
          if (pred_valid && pred_ready) begin
            pred_valid <= 1'b0;
            got_q      <= '0;
            cnt_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_vote_agg.sv
// Self-checking bench for rf_vote_agg: directed scenarios plus randomized rounds,
// each result compared with a vote-tally reference model.
module tb_rf_vote_agg;

  localparam int N   = 5;
  localparam int CLW = 2;
  localparam int NCL = 4;
  localparam int CW  = 3;
  localparam int RW  = CLW + CW + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*CLW-1:0] tree_class;
  logic [N-1:0]     tree_done;
  logic             clear;
  logic [CLW-1:0]   pred_class;
  logic [CW-1:0]    pred_conf;
  logic             pred_tie;
  logic             pred_valid;
  logic             pred_ready;
  logic             busy;
  logic             overrun;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  rf_vote_agg dut (
    .clk        (clk),
    .rst        (rst),
    .tree_class (tree_class),
    .tree_done  (tree_done),
    .clear      (clear),
    .pred_class (pred_class),
    .pred_conf  (pred_conf),
    .pred_tie   (pred_tie),
    .pred_valid (pred_valid),
    .pred_ready (pred_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Tally the votes, find the highest tally, then the first class holding it.
  function automatic logic [RW-1:0] ref_vote(input int cls[N]);
    int tally[NCL];
    int top, win, holders;
    for (int c = 0; c < NCL; c++) tally[c] = 0;
    for (int t = 0; t < N; t++) if (cls[t] < NCL) tally[cls[t]] += 1;
    top = 0;
    for (int c = 0; c < NCL; c++) if (tally[c] > top) top = tally[c];
    win = -1;
    holders = 0;
    for (int c = 0; c < NCL; c++) begin
      if (tally[c] == top) begin
        holders++;
        if (win < 0) win = c;
      end
    end
    return {CLW'(win), CW'(top), (holders > 1) ? 1'b1 : 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  // Pulse tree t at cycle slot[t]; returns at the negedge after the last latching edge.
  task automatic drive_votes(input int cls[N], input int slot[N]);
    int maxs = 0;
    for (int t = 0; t < N; t++) if (slot[t] > maxs) maxs = slot[t];
    for (int c = 0; c <= maxs; c++) begin
      @(negedge clk);
      tree_done = '0;
      for (int t = 0; t < N; t++) begin
        tree_class[t*CLW +: CLW] = CLW'(cls[t]);
        if (slot[t] == c) tree_done[t] = 1'b1;
      end
    end
    @(negedge clk);
    tree_done = '0;
  endtask

  // Counts negedges (one per clock) until pred_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (pred_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    pred_ready = 1'b1;
    @(negedge clk);
    pred_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; pred_ready = 1'b0; tree_done = '0; tree_class = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pred_valid); end
    total++; if (pred_class !== '0) begin bad++; $display("FAIL reset_class got=%0d want=0", pred_class); end
    total++; if (pred_conf !== '0) begin bad++; $display("FAIL reset_conf got=%0d want=0", pred_conf); end
    total++; if (pred_tie !== 1'b0) begin bad++; $display("FAIL reset_tie got=%b want=0", pred_tie); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_simultaneous();
    int cls[N] = '{1, 1, 2, 1, 3};
    int slot[N] = '{0, 0, 0, 0, 0};
    logic [RW-1:0] exp_r = ref_vote(cls);
    int lat;
    drive_votes(cls, slot);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sim_busy got=%b want=1", busy); end
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL sim_latency got=%0d want=6", lat); end
    total++; if ({pred_class, pred_conf, pred_tie} !== exp_r) begin bad++; $display("FAIL sim_result got=%h want=%h", {pred_class, pred_conf, pred_tie}, exp_r); end
    total++; if ({pred_class, pred_conf, pred_tie} !== {2'd1, 3'd3, 1'b0}) begin bad++; $display("FAIL sim_fixed got=%h want=%h", {pred_class, pred_conf, pred_tie}, {2'd1, 3'd3, 1'b0}); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL sim_overrun got=%b want=0", overrun); end
    handshake();
    total++; if ({pred_valid, busy} !== 2'b00) begin bad++; $display("FAIL sim_retire got=%b want=00", {pred_valid, busy}); end
  endtask

  task automatic test_staggered();
    int cls[N] = '{2, 2, 0, 0, 1};
    int slot[N] = '{1, 3, 2, 4, 0};
    logic [RW-1:0] exp_r = ref_vote(cls);
    int lat;
    drive_votes(cls, slot);
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL stag_latency got=%0d want=6", lat); end
    total++; if ({pred_class, pred_conf, pred_tie} !== exp_r) begin bad++; $display("FAIL stag_result got=%h want=%h", {pred_class, pred_conf, pred_tie}, exp_r); end
    total++; if ({pred_class, pred_conf, pred_tie} !== {2'd0, 3'd2, 1'b1}) begin bad++; $display("FAIL stag_fixed got=%h want=%h", {pred_class, pred_conf, pred_tie}, {2'd0, 3'd2, 1'b1}); end
    handshake();
  endtask

  task automatic test_all_three();
    int cls[N] = '{3, 3, 3, 3, 3};
    int slot[N] = '{0, 1, 0, 1, 2};
    int lat;
    drive_votes(cls, slot);
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL all3_latency got=%0d want=6", lat); end
    total++; if ({pred_class, pred_conf, pred_tie} !== {2'd3, 3'd5, 1'b0}) begin bad++; $display("FAIL all3_result got=%h want=%h", {pred_class, pred_conf, pred_tie}, {2'd3, 3'd5, 1'b0}); end
    handshake();
  endtask

  task automatic test_double_pulse();
    int cls[N] = '{2, 2, 2, 1, 1};
    logic [RW-1:0] exp_r = ref_vote(cls);
    int lat;
    @(negedge clk);
    for (int t = 0; t < N; t++) tree_class[t*CLW +: CLW] = CLW'(cls[t]);
    tree_done = 5'b00111;
    @(negedge clk);
    tree_class[2*CLW +: CLW] = 2'd1;
    tree_done = 5'b00100;
    @(negedge clk);
    tree_done = 5'b11000;
    @(negedge clk);
    tree_done = '0;
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL dbl_latency got=%0d want=6", lat); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL dbl_overrun got=%b want=1", overrun); end
    total++; if ({pred_class, pred_conf, pred_tie} !== exp_r) begin bad++; $display("FAIL dbl_result got=%h want=%h", {pred_class, pred_conf, pred_tie}, exp_r); end
    handshake();
  endtask

  task automatic test_clear();
    int old_cls[N] = '{0, 0, 0, 0, 0};
    int old_slot[N] = '{0, 0, 0, 0, 0};
    int cls[N] = '{2, 3, 2, 3, 2};
    int slot[N] = '{0, 3, 1, 1, 2};
    logic [RW-1:0] exp_r = ref_vote(cls);
    int lat;
    drive_votes(old_cls, old_slot);
    @(negedge clk);
    clear = 1'b1;
    tree_done = 5'b00010;
    @(negedge clk);
    clear = 1'b0;
    tree_done = '0;
    total++; if ({pred_valid, busy, overrun} !== 3'b000) begin bad++; $display("FAIL clr_flags got=%b want=000", {pred_valid, busy, overrun}); end
    total++; if ({pred_class, pred_conf, pred_tie} !== '0) begin bad++; $display("FAIL clr_pred got=%h want=0", {pred_class, pred_conf, pred_tie}); end
    repeat (8) @(negedge clk);
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL clr_no_result got=%b want=0", pred_valid); end
    drive_votes(cls, slot);
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL clr_latency got=%0d want=6", lat); end
    total++; if ({pred_class, pred_conf, pred_tie} !== exp_r) begin bad++; $display("FAIL clr_result got=%h want=%h", {pred_class, pred_conf, pred_tie}, exp_r); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun got=%b want=0", overrun); end
    handshake();
  endtask

  task automatic test_hold_ready();
    int cls[N] = '{1, 3, 3, 1, 0};
    int slot[N] = '{0, 0, 1, 1, 1};
    int nxt[N] = '{0, 1, 0, 1, 0};
    logic [RW-1:0] exp_r = ref_vote(cls);
    logic [RW-1:0] exp_n = ref_vote(nxt);
    int lat;
    drive_votes(cls, slot);
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL hold_latency got=%0d want=6", lat); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL hold_overrun0 got=%b want=0", overrun); end
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({pred_valid, pred_class, pred_conf, pred_tie} !== {1'b1, exp_r}) begin
        bad++; $display("FAIL hold_stable cyc=%0d got=%h want=%h", c, {pred_valid, pred_class, pred_conf, pred_tie}, {1'b1, exp_r});
      end
      tree_done = (c == 4) ? 5'b00001 : 5'b00000;
      @(negedge clk);
    end
    tree_done = '0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL hold_overrun1 got=%b want=1", overrun); end
    pred_ready = 1'b1;
    @(negedge clk);
    pred_ready = 1'b0;
    total++; if ({pred_valid, busy} !== 2'b00) begin bad++; $display("FAIL hold_retire got=%b want=00", {pred_valid, busy}); end
    for (int t = 0; t < N; t++) tree_class[t*CLW +: CLW] = CLW'(nxt[t]);
    tree_done = '1;
    @(negedge clk);
    tree_done = '0;
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL hold_next_latency got=%0d want=6", lat); end
    total++; if ({pred_class, pred_conf, pred_tie} !== exp_n) begin bad++; $display("FAIL hold_next_result got=%h want=%h", {pred_class, pred_conf, pred_tie}, exp_n); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int cls[N] = '{0, 0, 1, 2, 2};
    int slot[N] = '{0, 1, 2, 3, 4};
    logic [RW-1:0] exp_r = ref_vote(cls);
    int lat;
    @(negedge clk);
    tree_class = '1;
    tree_done = 5'b00011;
    @(negedge clk);
    tree_done = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({pred_valid, busy, overrun} !== 3'b000) begin bad++; $display("FAIL rstm_flags got=%b want=000", {pred_valid, busy, overrun}); end
    total++; if ({pred_class, pred_conf, pred_tie} !== '0) begin bad++; $display("FAIL rstm_pred got=%h want=0", {pred_class, pred_conf, pred_tie}); end
    drive_votes(cls, slot);
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL rstm_latency got=%0d want=6", lat); end
    total++; if ({pred_class, pred_conf, pred_tie} !== exp_r) begin bad++; $display("FAIL rstm_result got=%h want=%h", {pred_class, pred_conf, pred_tie}, exp_r); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstm_overrun got=%b want=0", overrun); end
    handshake();
  endtask

  task automatic test_random();
    int cls[N];
    int slot[N];
    int lat, wait_cyc;
    logic early;
    logic [RW-1:0] exp_r;
    for (int r = 0; r < 25; r++) begin
      for (int t = 0; t < N; t++) begin
        cls[t]  = $urandom_range(0, NCL - 1);
        slot[t] = $urandom_range(0, 3);
      end
      exp_q.push_back(ref_vote(cls));
      early = 1'($urandom_range(0, 1));
      pred_ready = early;
      drive_votes(cls, slot);
      wait_valid(lat);
      exp_r = exp_q.pop_front();
      total++; if (lat != 6) begin bad++; $display("FAIL rnd_latency round=%0d got=%0d want=6", r, lat); end
      total++; if ({pred_class, pred_conf, pred_tie} !== exp_r) begin bad++; $display("FAIL rnd_result round=%0d got=%h want=%h", r, {pred_class, pred_conf, pred_tie}, exp_r); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rnd_overrun round=%0d got=%b want=0", r, overrun); end
      if (early) begin
        @(negedge clk);
        pred_ready = 1'b0;
      end else begin
        wait_cyc = $urandom_range(0, 3);
        repeat (wait_cyc) @(negedge clk);
        total++; if ({pred_valid, pred_class, pred_conf, pred_tie} !== {1'b1, exp_r}) begin bad++; $display("FAIL rnd_hold round=%0d got=%h want=%h", r, {pred_valid, pred_class, pred_conf, pred_tie}, {1'b1, exp_r}); end
        handshake();
      end
      total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL rnd_retire round=%0d got=%b want=0", r, pred_valid); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_simultaneous();
    test_staggered();
    test_all_three();
    test_double_pulse();
    test_clear();
    test_hold_ready();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
